// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Optional performance counters (stall_cnt, flush_cnt) exist only when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_skid #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
`ifdef PIPE_STAGE_PERF_EN
  ,
  parameter int unsigned      CNT_W     = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_main_nxt;
  logic [WIDTH-1:0] w_skid_nxt;
  logic             r_out_valid;
  logic             r_in_ready;
  logic [1:0]       r_occ;
  logic             w_out_valid_nxt;
  logic             w_in_ready_nxt;
  logic [1:0]       w_occ_nxt;
  logic             w_in_fire;
  logic             w_out_fire;

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  // State, payload and the registered handshake flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_EMPTY;
      r_main      <= RESET_VAL;
      r_skid      <= RESET_VAL;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_occ       <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_main      <= w_main_nxt;
      r_skid      <= w_skid_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_occ       <= w_occ_nxt;
    end
  end

  // Next state; flush overrides any handshake in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      w_state_nxt = S_EMPTY;
      w_main_nxt  = RESET_VAL;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            w_main_nxt  = in_data;
            w_state_nxt = S_ONE;
          end
        end
        S_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_nxt = in_data;
          end else if (w_in_fire) begin
            w_skid_nxt  = in_data;
            w_state_nxt = S_FULL;
          end else if (w_out_fire) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_out_fire) begin
            w_main_nxt  = r_skid;
            w_state_nxt = S_ONE;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
    w_out_valid_nxt = (w_state_nxt != S_EMPTY);
    w_in_ready_nxt  = (w_state_nxt != S_FULL);
    case (w_state_nxt)
      S_ONE:   w_occ_nxt = 2'd1;
      S_FULL:  w_occ_nxt = 2'd2;
      default: w_occ_nxt = 2'd0;
    endcase
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main;
  assign occupancy = r_occ;

`ifdef PIPE_STAGE_PERF_EN
  localparam int unsigned  SUM_W   = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [SUM_W-1:0] w_flush_sum;

  assign w_flush_sum = SUM_W'(r_flush_cnt) + SUM_W'(r_occ);

  // Saturating counters; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (r_out_valid && !out_ready && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (flush) begin
        r_flush_cnt <= (w_flush_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(w_flush_sum);
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus random traffic against a queue-based model.
module tb_pipe_stage_skid;

  localparam int unsigned      W   = 16;
  localparam logic [W-1:0]     RV  = 16'h5A5A;
  localparam int unsigned      CW  = 3;
  localparam int               CMAX = (1 << CW) - 1;

  logic         clk;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: FIFO of held entries, last presented value, counters.
  logic [W-1:0] m_q[$];
  logic [W-1:0] m_last;
  int           m_stall;
  int           m_flush;

`ifdef PIPE_STAGE_PERF_EN
  pipe_stage_skid #(.WIDTH(W), .RESET_VAL(RV), .CNT_W(CW)) dut (
`else
  pipe_stage_skid #(.WIDTH(W), .RESET_VAL(RV)) dut (
`endif
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    check("in_ready",  32'(in_ready),  32'(m_q.size() < 2));
    check("occupancy", 32'(occupancy), 32'(m_q.size()));
    check("out_data",  32'(out_data),  32'((m_q.size() != 0) ? m_q[0] : m_last));
`ifdef PIPE_STAGE_PERF_EN
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
`endif
  endtask

  // Apply one cycle of inputs, advance the model by the handshake rules, check after the edge.
  task automatic step(input logic rst, input logic fl, input logic iv,
                      input logic [W-1:0] d, input logic ordy);
    logic in_fire, out_fire;
    reset = rst; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
    in_fire  = iv && (m_q.size() < 2);
    out_fire = (m_q.size() != 0) && ordy;
    if (rst) begin
      m_q.delete();
      m_last  = RV;
      m_stall = 0;
      m_flush = 0;
    end else begin
      if ((m_q.size() != 0) && !ordy && m_stall < CMAX) m_stall++;
      if (fl) begin
        m_flush = (m_flush + m_q.size() > CMAX) ? CMAX : m_flush + m_q.size();
        m_q.delete();
        m_last = RV;
      end else begin
        if (out_fire) m_last = m_q.pop_front();
        if (in_fire) m_q.push_back(d);
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    m_last = RV; m_stall = 0; m_flush = 0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    step(1, 0, 0, '0, 0);
    step(1, 0, 0, '0, 0);

    // Fill to FULL then reset for two cycles.
    step(0, 0, 1, 16'h0001, 0);
    step(0, 0, 1, 16'h0002, 0);
    check("full_before_reset", 32'(occupancy), 32'd2);
    step(1, 0, 1, 16'h0003, 0);
    step(1, 0, 0, '0, 0);

    // Back-to-back streaming with the sink always ready.
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, W'(16'h0011 + i), 1);
      check("stream_data", 32'(out_data), 32'(16'h0011 + i));
    end
    step(0, 0, 0, '0, 1);

    // Back-pressure: third item refused while FULL, then drain in order.
    step(0, 0, 1, 16'h000A, 0);
    step(0, 0, 1, 16'h000B, 0);
    step(0, 0, 1, 16'h000C, 0);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    step(0, 0, 0, '0, 1);
    check("bp_second", 32'(out_data), 32'h000B);
    step(0, 0, 0, '0, 1);

    // Flush while FULL with a concurrent push.
    step(0, 0, 1, 16'h0031, 0);
    step(0, 0, 1, 16'h0032, 0);
    step(0, 1, 1, 16'h000D, 0);
    check("flush_data", 32'(out_data), 32'(RV));

    // Simultaneous push and pop in ONE.
    step(0, 0, 1, 16'h0021, 0);
    step(0, 0, 1, 16'h0022, 1);
    check("passthru_data", 32'(out_data), 32'h0022);
    step(0, 0, 0, '0, 1);

`ifdef PIPE_STAGE_PERF_EN
    // Long stall saturates the stall counter; reset clears it.
    step(0, 0, 1, 16'h0041, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 0, '0, 0);
    check("stall_sat", 32'(stall_cnt), 32'(CMAX));
    step(1, 0, 0, '0, 0);
`endif

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      logic r, f, v, o;
      r = ($urandom_range(0, 99) == 0);
      f = ($urandom_range(0, 15) == 0);
      v = ($urandom_range(0, 3) != 0);
      o = (i % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      step(r, f, v, W'($urandom), o);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
